hazard_resolver_param: RTL and testbench

Parametrised pipeline hazard resolver: second-generation successor to the single-channel hazard FSM. It sits beside the pipeline control and turns per-cycle hazard indications into registered stall, flush and forward-enable commands. Hazards are ranked control > data > structural. New relative to the first generation:
- N structural resources, with a per-resource busy mask;
- configurable flush length;
- branch-resolution and data-stall timeouts;
- saturating performance counters.

---
 rtl/hazard_resolver_param.sv | 126 ++++++++++++
 tb/tb_hazard_resolver_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_resolver_param.sv
// Pipeline hazard resolver: ranks control > data > structural hazards and issues
// registered stall/flush/forward commands, with timeouts and saturating perf counters.
module hazard_resolver_param #(
  parameter int NUM_RES    = 2,
  parameter int FLUSH_CYC  = 2,
  parameter int BR_TIMEOUT = 4,
  parameter int MAX_DSTALL = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_haz,
  input  logic               fwd_ok,
  input  logic [NUM_RES-1:0] str_req,
  input  logic               ctrl_haz,
  input  logic               br_resolved,
  input  logic               br_correct,
  output logic               stall,
  output logic               flush,
  output logic               fwd_en,
  output logic [NUM_RES-1:0] str_busy,
  output logic [2:0]         state,
  output logic               br_to_err,
  output logic               dstall_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_DSTALL = 3'd2,
    S_SSTALL = 3'd3,
    S_CWAIT  = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  localparam logic [7:0] D_LAST = 8'(MAX_DSTALL - 1);
  localparam logic [7:0] B_LAST = 8'(BR_TIMEOUT - 1);
  localparam logic [3:0] F_LAST = 4'(FLUSH_CYC - 1);

  state_t     cur, nxt;
  logic [7:0] dcnt, bcnt;
  logic [3:0] fcnt;
  logic       mp, gr, dst_to, br_to;

  assign mp    = ctrl_haz & br_resolved & ~br_correct;
  assign gr    = ctrl_haz & br_resolved &  br_correct;
  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= S_IDLE;
      dcnt       <= '0;
      bcnt       <= '0;
      fcnt       <= '0;
      str_busy   <= '0;
      br_to_err  <= 1'b0;
      dstall_err <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      cur <= nxt;
      // Episode counters restart whenever the state is (re)entered.
      dcnt     <= (cur == S_DSTALL && nxt == S_DSTALL) ? dcnt + 8'd1 : 8'd0;
      bcnt     <= (cur == S_CWAIT  && nxt == S_CWAIT)  ? bcnt + 8'd1 : 8'd0;
      fcnt     <= (cur == S_FLUSH  && nxt == S_FLUSH)  ? fcnt + 4'd1 : 4'd0;
      str_busy <= (nxt == S_SSTALL) ? str_req : '0;
      if (dst_to) dstall_err <= 1'b1;
      if (br_to)  br_to_err  <= 1'b1;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (nxt == S_FLUSH && cur != S_FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt    = cur;
    dst_to = 1'b0;
    br_to  = 1'b0;
    case (cur)
      S_IDLE, S_FWD, S_DSTALL, S_SSTALL: begin
        // A good resolve falls through to the data/structural rules.
        if (mp)                            nxt = S_FLUSH;
        else if (ctrl_haz && !br_resolved) nxt = S_CWAIT;
        else if (data_haz && fwd_ok)       nxt = S_FWD;
        else if (data_haz) begin
          if (cur == S_DSTALL && dcnt == D_LAST) begin
            nxt    = S_IDLE;
            dst_to = 1'b1;
          end else begin
            nxt = S_DSTALL;
          end
        end
        else if (|str_req)                 nxt = S_SSTALL;
        else                               nxt = S_IDLE;
      end
      S_CWAIT: begin
        if (mp)                  nxt = S_FLUSH;
        else if (gr)             nxt = S_IDLE;
        else if (!ctrl_haz)      nxt = S_IDLE;
        else if (bcnt == B_LAST) begin
          nxt   = S_FLUSH;
          br_to = 1'b1;
        end
        else                     nxt = S_CWAIT;
      end
      S_FLUSH: nxt = (fcnt == F_LAST) ? S_IDLE : S_FLUSH;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    fwd_en = 1'b0;
    case (cur)
      S_DSTALL, S_SSTALL, S_CWAIT: stall  = 1'b1;
      S_FLUSH:                     flush  = 1'b1;
      S_FWD:                       fwd_en = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_resolver_param.sv
// Directed bench for hazard_resolver_param: vector table plus hand-written
// sequences for timeouts, sticky flags, counters and a narrow second instance.
module tb_hazard_resolver_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_haz, fwd_ok, ctrl_haz, br_resolved, br_correct;
  logic [1:0]  str_req;
  logic        stall, flush, fwd_en, br_to_err, dstall_err;
  logic [1:0]  str_busy;
  logic [2:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        stall2, flush2, fwd_en2, br_to_err2, dstall_err2;
  logic [0:0]  str_busy2;
  logic [2:0]  state2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_resolver_param dut (
    .clk(clk), .rst(rst), .data_haz(data_haz), .fwd_ok(fwd_ok), .str_req(str_req),
    .ctrl_haz(ctrl_haz), .br_resolved(br_resolved), .br_correct(br_correct),
    .stall(stall), .flush(flush), .fwd_en(fwd_en), .str_busy(str_busy), .state(state),
    .br_to_err(br_to_err), .dstall_err(dstall_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_resolver_param #(.NUM_RES(1), .FLUSH_CYC(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .data_haz(data_haz), .fwd_ok(fwd_ok), .str_req(str_req[0]),
    .ctrl_haz(ctrl_haz), .br_resolved(br_resolved), .br_correct(br_correct),
    .stall(stall2), .flush(flush2), .fwd_en(fwd_en2), .str_busy(str_busy2), .state(state2),
    .br_to_err(br_to_err2), .dstall_err(dstall_err2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  typedef struct packed {
    logic       rst, dh, fo;
    logic [1:0] sr;
    logic       ch, br, bc;
    logic       st, fl, fe;
    logic [1:0] sb;
    logic [2:0] stt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, dh, fo, input logic [1:0] sr, input logic ch, br, bc,
                     input logic st, fl, fe, input logic [1:0] sb, input logic [2:0] stt);
    vec_t v;
    v = '{rst:r, dh:dh, fo:fo, sr:sr, ch:ch, br:br, bc:bc, st:st, fl:fl, fe:fe, sb:sb, stt:stt};
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, dh, fo, input logic [1:0] sr, input logic ch, br, bc);
    rst = r; data_haz = dh; fwd_ok = fo; str_req = sr;
    ctrl_haz = ch; br_resolved = br; br_correct = bc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, flushes;
    //  rst dh fo sr    ch br bc | st fl fe sb    state
    add(1, 1, 0, 2'b11, 1, 0, 0,   0, 0, 0, 2'b00, 3'd0); // reset with busy inputs
    add(1, 0, 1, 2'b10, 1, 1, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 1, 1, 0,   0, 1, 0, 2'b00, 3'd5); // mispredict
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 1, 0, 2'b00, 3'd5);
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 1, 0, 2'b00, 0, 0, 0,   1, 0, 0, 2'b00, 3'd2); // data stall x3
    add(0, 1, 0, 2'b00, 0, 0, 0,   1, 0, 0, 2'b00, 3'd2);
    add(0, 1, 0, 2'b00, 0, 0, 0,   1, 0, 0, 2'b00, 3'd2);
    add(0, 1, 1, 2'b00, 0, 0, 0,   0, 0, 1, 2'b00, 3'd1); // forward
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b10, 0, 0, 0,   1, 0, 0, 2'b10, 3'd3); // structural mask
    add(0, 0, 0, 2'b10, 0, 0, 0,   1, 0, 0, 2'b10, 3'd3);
    add(0, 0, 0, 2'b11, 0, 0, 0,   1, 0, 0, 2'b11, 3'd3);
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 1, 0, 2'b00, 0, 0, 0,   1, 0, 0, 2'b00, 3'd2); // DSTALL preempted by MP
    add(0, 1, 0, 2'b00, 1, 1, 0,   0, 1, 0, 2'b00, 3'd5);
    add(0, 1, 0, 2'b11, 0, 0, 0,   0, 1, 0, 2'b00, 3'd5);
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 1, 0, 2'b00, 1, 0, 0,   1, 0, 0, 2'b00, 3'd4); // ctrl beats data
    add(0, 1, 0, 2'b00, 1, 1, 1,   0, 0, 0, 2'b00, 3'd0); // GR in CWAIT, data ignored
    add(0, 1, 1, 2'b00, 1, 1, 1,   0, 0, 1, 2'b00, 3'd1); // GR falls through to FWD
    add(0, 0, 0, 2'b00, 1, 1, 1,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 1, 0, 0,   1, 0, 0, 2'b00, 3'd4); // ctrl drops unresolved
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 1, 0, 2'b11, 1, 1, 0,   0, 1, 0, 2'b00, 3'd5); // MP with data+str: flush only
    add(0, 0, 0, 2'b00, 1, 1, 0,   0, 1, 0, 2'b00, 3'd5); // MP in FLUSH ignored
    add(0, 0, 0, 2'b00, 1, 1, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 1, 1, 0,   0, 1, 0, 2'b00, 3'd5); // reset mid-FLUSH
    add(1, 0, 0, 2'b00, 1, 1, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 1, 0, 0,   1, 0, 0, 2'b00, 3'd4); // reset mid-CWAIT
    add(1, 0, 0, 2'b00, 1, 0, 0,   0, 0, 0, 2'b00, 3'd0);
    add(0, 0, 0, 2'b00, 0, 0, 0,   0, 0, 0, 2'b00, 3'd0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].dh, vq[i].fo, vq[i].sr, vq[i].ch, vq[i].br, vq[i].bc);
      tick();
      chk($sformatf("vec%0d {st,fl,fe,sb,state}", i),
          32'({stall, flush, fwd_en, str_busy, state}),
          32'({vq[i].st, vq[i].fl, vq[i].fe, vq[i].sb, vq[i].stt}));
    end

    // Reset clears counters and sticky flags
    do_reset();
    chk("rst stall_cnt", 32'(stall_cnt), 0);
    chk("rst flush_cnt", 32'(flush_cnt), 0);
    chk("rst br_to_err", 32'(br_to_err), 0);
    chk("rst dstall_err", 32'(dstall_err), 0);

    // Mispredict from IDLE: two flush cycles, one episode, no stall
    stalls = 0; flushes = 0;
    drive(0, 0, 0, 2'b00, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stall) stalls++;
      if (flush) flushes++;
      drive(0, 0, 0, 2'b00, 0, 0, 0);
    end
    chk("mp flush cycles", flushes, 2);
    chk("mp stall cycles", stalls, 0);
    chk("mp flush_cnt", 32'(flush_cnt), 1);
    chk("mp state", 32'(state), 0);

    // Branch timeout: four CWAIT cycles then forced flush
    do_reset();
    stalls = 0; flushes = 0;
    drive(0, 0, 0, 2'b00, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (stall) stalls++;
      if (flush) flushes++;
    end
    chk("bto state", 32'(state), 5);
    chk("bto br_to_err", 32'(br_to_err), 1);
    chk("bto stall_cnt", 32'(stall_cnt), 4);
    chk("bto flush_cnt", 32'(flush_cnt), 1);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (flush) flushes++;
    end
    chk("bto stall cycles", stalls, 4);
    chk("bto flush cycles", flushes, 2);
    chk("bto end state", 32'(state), 0);

    // Data stall timeout after eight stall cycles; flag is sticky
    do_reset();
    drive(0, 1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("dto state@8", 32'(state), 2);
    chk("dto err@8", 32'(dstall_err), 0);
    tick();
    chk("dto state@9", 32'(state), 0);
    chk("dto err@9", 32'(dstall_err), 1);
    chk("dto stall_cnt", 32'(stall_cnt), 8);
    tick();
    chk("dto reenter", 32'(state), 2);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    chk("dto sticky", 32'(dstall_err), 1);
    do_reset();
    chk("dto cleared", 32'(dstall_err), 0);

    // Narrow instance: single-cycle flush, 2-bit counters saturate
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 2'b00, 1, 1, 0);
      tick();
      chk($sformatf("n1 flush on %0d", k), 32'(flush2), 1);
      drive(0, 0, 0, 2'b00, 0, 0, 0);
      tick();
      chk($sformatf("n1 flush off %0d", k), 32'(flush2), 0);
    end
    chk("n1 flush_cnt sat", 32'(flush_cnt2), 3);
    chk("wide flush_cnt", 32'(flush_cnt), 2);
    drive(0, 1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("n1 stall_cnt sat", 32'(stall_cnt2), 3);
    drive(0, 0, 0, 2'b01, 0, 0, 0);
    tick();
    chk("n1 str_busy", 32'(str_busy2), 1);
    chk("n1 state", 32'(state2), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
